// File: rtl/frac_div_pkg.sv
// Shared widths, limits and state encoding for the fractional-N divider.
package frac_div_pkg;

  localparam int N_W   = 8;
  localparam int F_W   = 8;
  localparam int N_MIN = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Divide ratios below N_MIN cannot produce a distinct pulse and toggle edge.
  function automatic logic [N_W-1:0] clamp_n(input logic [N_W-1:0] n);
    return (n < N_W'(N_MIN)) ? N_W'(N_MIN) : n;
  endfunction

endpackage

// File: rtl/frac_div_if.sv
// Configuration handshake between the divider and whoever programs it.
interface frac_div_if;
  import frac_div_pkg::*;

  logic           cfg_valid;
  logic           cfg_ready;
  logic [N_W-1:0] cfg_n;
  logic [F_W-1:0] cfg_frac;

  modport master (output cfg_valid, output cfg_n, output cfg_frac, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_n, input cfg_frac, output cfg_ready);

endinterface

// File: rtl/adder_8_bit.sv
// 8-bit ripple-carry adder used as the phase accumulator sum.
module adder_8_bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic [8:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[8];

endmodule

// File: rtl/frac_div_core.sv
// Fractional-N divide control: period counter plus phase accumulator whose
// carry stretches an output period by one clock.
//
// state | meaning
// IDLE  | stopped; configuration writes straight into the active set
// RUN   | counting periods; configuration is buffered until the next boundary
module frac_div_core
  import frac_div_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  frac_div_if.slave      cfg,
  output logic           div_pulse,
  output logic           div_out,
  output logic           mod_sel,
  output logic [F_W-1:0] acc_out
);

  state_t         r_state;
  logic [N_W-1:0] r_n_act;
  logic [F_W-1:0] r_f_act;
  logic [N_W-1:0] r_n_pend;
  logic [F_W-1:0] r_f_pend;
  logic           r_pend_v;
  logic [F_W-1:0] r_acc;
  logic [N_W-1:0] r_cnt;
  logic           r_div_pulse;
  logic           r_div_out;
  logic           r_mod_sel;

  logic           w_xfer;
  logic [N_W-1:0] w_n_cap;
  logic           w_boundary;
  logic [N_W-1:0] w_n_new;
  logic [F_W-1:0] w_f_new;
  logic [F_W-1:0] w_sum;
  logic           w_carry;
  logic [N_W-1:0] w_cnt_reload;

  assign cfg.cfg_ready = ~r_pend_v;
  assign w_xfer        = cfg.cfg_valid & ~r_pend_v;
  assign w_n_cap       = clamp_n(cfg.cfg_n);
  assign w_boundary    = (r_state == RUN) & en & (r_cnt == '0);
  assign w_n_new       = r_pend_v ? r_n_pend : r_n_act;
  assign w_f_new       = r_pend_v ? r_f_pend : r_f_act;

  // Carry-out of the accumulator add marks an N+1 period.
  adder_8_bit u_acc_add (
    .i_a    (r_acc),
    .i_b    (w_f_new),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_carry)
  );

  // N >= 2 keeps N-1+c within 8 bits.
  assign w_cnt_reload = w_n_new - N_W'(1) + {{(N_W-1){1'b0}}, w_carry};

  // Divider FSM, period counter, config buffering and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_n_act     <= N_W'(N_MIN);
      r_f_act     <= '0;
      r_n_pend    <= N_W'(N_MIN);
      r_f_pend    <= '0;
      r_pend_v    <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_div_pulse <= 1'b0;
      r_div_out   <= 1'b0;
      r_mod_sel   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_div_pulse <= 1'b0;
          if (w_xfer) begin
            r_n_act <= w_n_cap;
            r_f_act <= cfg.cfg_frac;
          end
          if (en) begin
            r_state   <= RUN;
            r_cnt     <= r_n_act - N_W'(1);
            r_acc     <= '0;
            r_mod_sel <= 1'b0;
          end
        end
        RUN: begin
          if (!en) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_div_out   <= 1'b0;
            r_mod_sel   <= 1'b0;
            r_div_pulse <= 1'b0;
            r_pend_v    <= 1'b0;
            // Buffered config becomes active; a fresh offer lands there directly.
            if (r_pend_v) begin
              r_n_act <= r_n_pend;
              r_f_act <= r_f_pend;
            end else if (w_xfer) begin
              r_n_act <= w_n_cap;
              r_f_act <= cfg.cfg_frac;
            end
          end else begin
            r_div_pulse <= w_boundary;
            if (w_boundary) begin
              r_n_act   <= w_n_new;
              r_f_act   <= w_f_new;
              r_acc     <= w_sum;
              r_cnt     <= w_cnt_reload;
              r_mod_sel <= w_carry;
              r_div_out <= ~r_div_out;
            end else begin
              r_cnt <= r_cnt - N_W'(1);
            end
            // An offer taken on a boundary waits for the following boundary.
            if (w_xfer) begin
              r_n_pend <= w_n_cap;
              r_f_pend <= cfg.cfg_frac;
              r_pend_v <= 1'b1;
            end else if (w_boundary) begin
              r_pend_v <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign div_pulse = r_div_pulse;
  assign div_out   = r_div_out;
  assign mod_sel   = r_mod_sel;
  assign acc_out   = r_acc;

endmodule

// File: tb/tb_frac_div_core.sv
// Directed and randomized bench for frac_div_core against a period-level model.
module tb_frac_div_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       div_pulse;
  logic       div_out;
  logic       mod_sel;
  logic [7:0] acc_out;

  int checks = 0;
  int errors = 0;

  // Model state: active ratio, accumulator phase, last carry, divided output level.
  int m_n;
  int m_f;
  int m_acc;
  int m_c;
  int m_div;

  frac_div_if cfg_if ();

  frac_div_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg       (cfg_if),
    .div_pulse (div_pulse),
    .div_out   (div_out),
    .mod_sel   (mod_sel),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!div_pulse && cyc < 600);
    if (!div_pulse) chk("pulse_timeout", 0, 1);
  endtask

  task automatic cfg_idle(input int n, input int f);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_n     = 8'(n);
    cfg_if.cfg_frac  = 8'(f);
    chk("ready_idle", int'(cfg_if.cfg_ready), 1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    m_n = (n < 2) ? 2 : n;
    m_f = f;
  endtask

  // At a pulse cycle: advance the phase model and compare the outputs.
  task automatic boundary_check();
    int s;
    s     = m_acc + m_f;
    m_c   = (s >= 256) ? 1 : 0;
    m_acc = s % 256;
    m_div = 1 - m_div;
    chk("acc_out", int'(acc_out), m_acc);
    chk("mod_sel", int'(mod_sel), m_c);
    chk("div_out", int'(div_out), m_div);
  endtask

  task automatic start_run();
    int c;
    en = 1'b1;
    tick();
    m_acc = 0;
    m_c   = 0;
    m_div = 0;
    wait_pulse(c);
    chk("first_period", c, m_n);
    boundary_check();
  endtask

  task automatic run_periods(input int k, output int total);
    int c;
    int exp_len;
    total = 0;
    for (int i = 0; i < k; i++) begin
      exp_len = m_n + m_c;
      wait_pulse(c);
      chk("period", c, exp_len);
      total += c;
      boundary_check();
    end
  endtask

  task automatic stop_run();
    int seen;
    en = 1'b0;
    tick();
    chk("stop_pulse", int'(div_pulse), 0);
    chk("stop_div_out", int'(div_out), 0);
    chk("stop_acc", int'(acc_out), 0);
    chk("stop_mod_sel", int'(mod_sel), 0);
    chk("stop_ready", int'(cfg_if.cfg_ready), 1);
    seen = 0;
    repeat (6) begin
      tick();
      if (div_pulse) seen++;
    end
    chk("idle_no_pulse", seen, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pulse"}, int'(div_pulse), 0);
    chk({tag, "_div_out"}, int'(div_out), 0);
    chk({tag, "_mod_sel"}, int'(mod_sel), 0);
    chk({tag, "_acc"}, int'(acc_out), 0);
    chk({tag, "_ready"}, int'(cfg_if.cfg_ready), 1);
  endtask

  initial begin
    int total;
    int c;
    int rn;
    int rf;

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_n     = 8'd0;
    cfg_if.cfg_frac  = 8'd0;

    // Reset held with enable high.
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    en    = 1'b0;
    rst_n = 1'b1;
    tick();

    // Reset default ratio is 2 + 0/256.
    m_n = 2;
    m_f = 0;
    start_run();
    run_periods(4, total);
    stop_run();

    // N=4, F=0, then a mid-run change to N=6 offered at cnt==2.
    cfg_idle(4, 0);
    start_run();
    run_periods(6, total);
    tick();
    chk("mid_ready_before", int'(cfg_if.cfg_ready), 1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_n     = 8'd6;
    cfg_if.cfg_frac  = 8'd0;
    tick();
    chk("mid_ready_low", int'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_n = 8'd9;
    tick();
    chk("mid_ready_still_low", int'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_valid = 1'b0;
    wait_pulse(c);
    chk("mid_current_period", c + 3, 4);
    chk("mid_ready_back", int'(cfg_if.cfg_ready), 1);
    m_n = 6;
    boundary_check();
    run_periods(3, total);
    stop_run();

    // N=4, F=128: periods 4,4,5,4,5...
    cfg_idle(4, 128);
    start_run();
    run_periods(10, total);
    stop_run();

    // N=10, F=64 over 256 periods after the first.
    cfg_idle(10, 64);
    start_run();
    run_periods(256, total);
    chk("n10_f64_total", total, 2624);
    stop_run();

    // Clamp N=1 and N=0 to 2.
    cfg_idle(1, 0);
    start_run();
    run_periods(6, total);
    stop_run();
    cfg_idle(0, 0);
    start_run();
    run_periods(3, total);
    stop_run();

    // Enable dropped mid-period.
    cfg_idle(7, 0);
    start_run();
    run_periods(2, total);
    tick();
    tick();
    stop_run();

    // Randomized ratios, including clamp cases, with enable dropped at a random phase.
    for (int r = 0; r < 8; r++) begin
      rn = $urandom_range(0, 20);
      rf = $urandom_range(0, 255);
      cfg_idle(rn, rf);
      start_run();
      run_periods(12, total);
      repeat ($urandom_range(0, 3)) tick();
      stop_run();
    end

    // Reset during RUN with a pending config: everything back to reset values.
    cfg_idle(5, 0);
    start_run();
    tick();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_n     = 8'd3;
    cfg_if.cfg_frac  = 8'd10;
    tick();
    cfg_if.cfg_valid = 1'b0;
    chk("pend_before_reset", int'(cfg_if.cfg_ready), 0);
    rst_n = 1'b0;
    en    = 1'b0;
    tick();
    check_reset_outputs("midrun_reset");
    rst_n = 1'b1;
    tick();
    m_n = 2;
    m_f = 0;
    start_run();
    run_periods(3, total);
    stop_run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
